// File: rtl/avalon_st_width_down_adapter_if.sv
// Avalon-ST bundle for the 32-bit to 8-bit width adapter.
// Carries the wide input stream and the byte output stream.
interface avalon_st_width_down_adapter_if #(
  parameter int SYMBOL_W   = 8,
  parameter int IN_SYMBOLS = 4,
  parameter int EMPTY_W    = 2,
  parameter int ERROR_W    = 6
);
  localparam int DATA_W = SYMBOL_W * IN_SYMBOLS;

  logic                in_ready;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic [ERROR_W-1:0]  in_error;
  logic                in_startofpacket;
  logic                in_endofpacket;
  logic [EMPTY_W-1:0]  in_empty;

  logic                out_ready;
  logic                out_valid;
  logic [SYMBOL_W-1:0] out_data;
  logic [ERROR_W-1:0]  out_error;
  logic                out_startofpacket;
  logic                out_endofpacket;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_error,
    input  in_startofpacket, in_endofpacket, in_empty,
    input  out_ready,
    output out_valid, out_data, out_error,
    output out_startofpacket, out_endofpacket
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_error,
    output in_startofpacket, in_endofpacket, in_empty,
    output out_ready,
    input  out_valid, out_data, out_error,
    input  out_startofpacket, out_endofpacket
  );
endinterface

// File: rtl/avalon_st_width_down_adapter.sv
// Avalon-ST width down adapter: one 4-symbol beat in,
// one symbol per cycle out, MSB symbol first.
module avalon_st_width_down_adapter #(
  parameter int SYMBOL_W   = 8,
  parameter int IN_SYMBOLS = 4,
  parameter int EMPTY_W    = 2,
  parameter int ERROR_W    = 6
) (
  input logic clk,
  input logic reset_n,
  avalon_st_width_down_adapter_if.slave st
);
  localparam int DATA_W = SYMBOL_W * IN_SYMBOLS;
  localparam logic [EMPTY_W-1:0] LAST_SYM =
    EMPTY_W'(IN_SYMBOLS - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ERROR_W-1:0]  err_q, err_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [EMPTY_W-1:0]  last_q, last_d;
  logic [EMPTY_W-1:0]  idx_q, idx_d;

  logic                busy;
  logic                is_last;
  logic                out_fire;
  logic                accept;
  logic [SYMBOL_W-1:0] sym;

  assign busy     = (state_q == S_BUSY);
  assign is_last  = (idx_q == last_q);
  assign out_fire = busy && st.out_ready;
  assign accept   = st.in_valid && st.in_ready;

  // A new beat may enter while idle or as the last symbol leaves.
  assign st.in_ready =
    reset_n && (!busy || (out_fire && is_last));

  // Select the held symbol at idx, symbol 0 at the MSB end.
  always_comb begin
    sym = '0;
    for (int i = 0; i < IN_SYMBOLS; i++) begin
      if (idx_q == EMPTY_W'(i)) begin
        sym = data_q[(IN_SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W];
      end
    end
  end

  // Next state: load on accept, else step through symbols.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = S_BUSY;
      data_d  = st.in_data;
      err_d   = st.in_error;
      sop_d   = st.in_startofpacket;
      eop_d   = st.in_endofpacket;
      last_d  = st.in_endofpacket ?
                LAST_SYM - st.in_empty : LAST_SYM;
      idx_d   = '0;
    end else if (out_fire) begin
      if (is_last) begin
        state_d = S_IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      err_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign st.out_valid = busy;
  assign st.out_data  = busy ? sym : '0;
  assign st.out_error = busy ? err_q : '0;
  assign st.out_startofpacket =
    busy && sop_q && (idx_q == '0);
  assign st.out_endofpacket =
    busy && eop_q && is_last;
endmodule

// File: tb/tb_avalon_st_width_down_adapter.sv
// Bench for avalon_st_width_down_adapter: directed
// scenarios plus random traffic against a symbol queue model.
module tb_avalon_st_width_down_adapter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  avalon_st_width_down_adapter_if bus ();

  avalon_st_width_down_adapter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .st      (bus.slave)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] err;
    logic       sop;
    logic       eop;
  } sym_t;

  sym_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic acc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs, then advance the model.
  task automatic step(input logic v, input logic [31:0] d,
                      input logic [5:0] e, input logic s,
                      input logic p, input logic [1:0] m,
                      input logic ordy, input logic rn);
    logic exp_rdy;
    int   n;
    sym_t x;
    @(negedge clk);
    reset_n              = rn;
    bus.in_valid         = v;
    bus.in_data          = d;
    bus.in_error         = e;
    bus.in_startofpacket = s;
    bus.in_endofpacket   = p;
    bus.in_empty         = m;
    bus.out_ready        = ordy;
    #1;
    exp_rdy = rn && (q.size() == 0 ||
                     (q.size() == 1 && ordy));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid),
        32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].data));
      chk("out_error", 32'(bus.out_error), 32'(q[0].err));
      chk("out_sop", 32'(bus.out_startofpacket),
          32'(q[0].sop));
      chk("out_eop", 32'(bus.out_endofpacket),
          32'(q[0].eop));
    end
    @(posedge clk);
    acc = v && exp_rdy;
    if (!rn) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
        n = p ? 4 - int'(m) : 4;
        for (int i = 0; i < n; i++) begin
          x.data = d[31 - 8*i -: 8];
          x.err  = e;
          x.sop  = s && (i == 0);
          x.eop  = p && (i == n - 1);
          q.push_back(x);
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, $urandom, 6'($urandom), 1'b0, 1'b0,
         2'($urandom), ordy, 1'b1);
  endtask

  task automatic send(input logic [31:0] d,
                      input logic [5:0] e, input logic s,
                      input logic p, input logic [1:0] m);
    for (int k = 0; k < 50; k++) begin
      step(1'b1, d, e, s, p, m, 1'b1, 1'b1);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic rdy_pat [4];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++)
      step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_error", 32'(bus.out_error), 32'd0);
    chk("rst_sop", 32'(bus.out_startofpacket), 32'd0);
    chk("rst_eop", 32'(bus.out_endofpacket), 32'd0);

    send(32'hAABBCCDD, 6'h00, 1'b1, 1'b0, 2'd0);
    repeat (5) idle(1'b1);

    send(32'h01020304, 6'h00, 1'b1, 1'b0, 2'd0);
    send(32'h05060708, 6'h00, 1'b0, 1'b1, 2'd0);
    repeat (5) idle(1'b1);

    send(32'h11223344, 6'h21, 1'b1, 1'b1, 2'd2);
    send(32'h55667788, 6'h00, 1'b1, 1'b1, 2'd0);
    repeat (5) idle(1'b1);

    send(32'hDEADBEEF, 6'h00, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 12; i++) idle(rdy_pat[i % 4]);

    send(32'hCAFEF00D, 6'h05, 1'b1, 1'b1, 2'd0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b1);
    send(32'h0A0B0C0D, 6'h00, 1'b1, 1'b1, 2'd0);
    repeat (5) idle(1'b1);

    send(32'h7F123456, 6'h3F, 1'b1, 1'b1, 2'd3);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           6'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) != 0);
    end
    repeat (6) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
